// File: rtl/shl8_arb.sv
`default_nettype none
// ============================================================================
// Module      : shl8_arb
// Description : Two-port round-robin arbiter that shares one 8-bit left
//               shifter and holds a single registered result for its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module shl8_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [2:0] req0_shift,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [2:0] req1_shift,
    output logic       req1_ready,
    output logic [1:0] rsp_valid,
    output logic [7:0] rsp_res,
    output logic       rsp_carry,
    input  logic [1:0] rsp_ready,
    output logic       busy
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_owner;
    logic       r_last;
    logic [7:0] r_res;
    logic       r_carry;

    logic       w_free;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_acc0;
    logic       w_acc1;
    logic       w_acc;
    logic [7:0] w_op_a;
    logic [2:0] w_op_s;
    logic [8:0] w_shifted;

    // Slot can take a new result when empty or when its owner drains it now.
    assign w_free   = (r_state == c_IDLE) | rsp_ready[r_owner];

    assign w_grant0 = req0_valid & (~req1_valid | r_last);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready = rst_n & w_grant0 & w_free;
    assign req1_ready = rst_n & w_grant1 & w_free;

    assign w_acc0 = req0_valid & req0_ready;
    assign w_acc1 = req1_valid & req1_ready;
    assign w_acc  = w_acc0 | w_acc1;

    assign w_op_a = w_acc1 ? req1_a     : req0_a;
    assign w_op_s = w_acc1 ? req1_shift : req0_shift;

    // Bit 8 of the widened shift is exactly the last bit shifted out (0 for s=0).
    assign w_shifted = {1'b0, w_op_a} << w_op_s;

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = c_HOLD;
        end else if ((r_state == c_HOLD) && rsp_ready[r_owner]) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_res   <= 8'h00;
            r_carry <= 1'b0;
        end else if (w_acc) begin
            r_owner <= w_acc1;
            r_last  <= w_acc1;
            r_res   <= w_shifted[7:0];
            r_carry <= w_shifted[8];
        end
    end

    assign rsp_valid = {(r_state == c_HOLD) &  r_owner,
                        (r_state == c_HOLD) & ~r_owner};
    assign rsp_res   = r_res;
    assign rsp_carry = r_carry;
    assign busy      = |rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_shl8_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_shl8_arb
// Description : Self-checking bench for shl8_arb: directed scenarios plus a
//               randomized run compared cycle by cycle to a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shl8_arb;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [2:0] req0_shift;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [2:0] req1_shift;
    logic       req1_ready;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_res;
    logic       rsp_carry;
    logic [1:0] rsp_ready;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    shl8_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_shift (req0_shift),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_shift (req1_shift),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_res    (rsp_res),
        .rsp_carry  (rsp_carry),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int winner(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return (last == 1'b0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // {carry, res}: multiply by 2^s, keep the low byte, carry is the bit that
    // landed just above it.
    function automatic logic [8:0] shl_ref(input logic [7:0] a, input logic [2:0] s);
        int p;
        p = int'(a) * (1 << s);
        return {(s != 3'd0) && (((p / 256) % 2) == 1), 8'(p % 256)};
    endfunction

    logic       m_full  = 1'b0;
    logic       m_owner = 1'b0;
    logic       m_last  = 1'b1;
    logic [7:0] m_res   = 8'h00;
    logic       m_carry = 1'b0;

    int         m_win;
    logic       m_free;
    logic [8:0] m_new;

    always_comb begin
        m_win  = winner(req0_valid, req1_valid, m_last);
        m_free = !m_full || rsp_ready[m_owner];
        m_new  = (m_win == 1) ? shl_ref(req1_a, req1_shift) : shl_ref(req0_a, req0_shift);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full  <= 1'b0;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_res   <= 8'h00;
            m_carry <= 1'b0;
        end else if (m_win >= 0 && m_free) begin
            m_full  <= 1'b1;
            m_owner <= (m_win == 1);
            m_last  <= (m_win == 1);
            m_res   <= m_new[7:0];
            m_carry <= m_new[8];
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full  <= 1'b0;
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, rst_n && m_win == 0 && m_free});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, rst_n && m_win == 1 && m_free});
        chk("rsp_valid", {30'd0, rsp_valid},
            {30'd0, m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00});
        chk("busy", {31'd0, busy}, {31'd0, m_full});
        if (m_full) begin
            chk("rsp_res", {24'd0, rsp_res}, {24'd0, m_res});
            chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, m_carry});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [7:0] sw_a   [4] = '{8'hA5, 8'hFF, 8'h81, 8'h40};
    logic [2:0] sw_s   [4] = '{3'd0, 3'd4, 3'd7, 3'd2};
    logic [7:0] sw_res [4] = '{8'hA5, 8'hF0, 8'h80, 8'h00};
    logic       sw_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic acc0;
    logic acc1;

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 8'h00;
        req0_shift = 3'd0;
        req1_valid = 1'b0;
        req1_a     = 8'h00;
        req1_shift = 3'd0;
        rsp_ready  = 2'b11;

        // Reset state with a request pending
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        chk("rst_rsp_res", {24'd0, rsp_res}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'h0);
        tick();
        rst_n      = 1'b1;

        // Port 0 only: 0x81 << 1
        req0_a     = 8'h81;
        req0_shift = 3'd1;
        @(negedge clk);
        chk("p0_ready", {31'd0, req0_ready}, 32'h1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("p0_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("p0_res", {24'd0, rsp_res}, 32'h02);
        chk("p0_carry", {31'd0, rsp_carry}, 32'h1);
        tick();

        // Shift-rule sweep through port 1
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1;
            req1_a     = sw_a[i];
            req1_shift = sw_s[i];
            tick();
            req1_valid = 1'b0;
            @(negedge clk);
            chk("sweep_rsp_valid", {30'd0, rsp_valid}, 32'h2);
            chk("sweep_res", {24'd0, rsp_res}, {24'd0, sw_res[i]});
            chk("sweep_carry", {31'd0, rsp_carry}, {31'd0, sw_c[i]});
            tick();
        end

        // Continuous contention alternates starting with port 0 after reset
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h11; req0_shift = 3'd1;
        req1_valid = 1'b1; req1_a = 8'h22; req1_shift = 3'd2;
        rsp_ready  = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            chk("alt_rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("alt_res", {24'd0, rsp_res}, (i % 2 == 0) ? 32'h22 : 32'h88);
        end
        tick();

        // Backpressure on port 0 while port 1 waits
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_shift = 3'd2;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h07; req1_shift = 3'd5;
        rsp_ready  = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'h0);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'h0);
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
            chk("bp_res", {24'd0, rsp_res}, 32'hF0);
            chk("bp_carry", {31'd0, rsp_carry}, 32'h0);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_release_req1_ready", {31'd0, req1_ready}, 32'h1);
        tick();
        req1_valid = 1'b0;
        rsp_ready  = 2'b01;
        @(negedge clk);
        chk("bp_p1_rsp_valid", {30'd0, rsp_valid}, 32'h2);
        chk("bp_p1_res", {24'd0, rsp_res}, 32'hE0);
        chk("bp_p1_carry", {31'd0, rsp_carry}, 32'h0);
        tick();

        // Non-owner consumer-ready is ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nonowner_rsp_valid", {30'd0, rsp_valid}, 32'h2);
            chk("nonowner_busy", {31'd0, busy}, 32'h1);
            tick();
        end

        // Reset in HOLD with requests pending
        req0_valid = 1'b1; req0_a = 8'h01; req0_shift = 3'd3;
        req1_valid = 1'b1; req1_a = 8'h02; req1_shift = 3'd3;
        rsp_ready  = 2'b00;
        @(negedge clk);
        chk("hold_req0_ready", {31'd0, req0_ready}, 32'h0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'h0);
        chk("midrst_res", {24'd0, rsp_res}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'h0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("postrst_req0_ready", {31'd0, req0_ready}, 32'h1);
        chk("postrst_req1_ready", {31'd0, req1_ready}, 32'h0);
        tick();
        @(negedge clk);
        chk("postrst_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("postrst_res", {24'd0, rsp_res}, 32'h08);

        // Randomized run; operands held stable until accepted
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            tick();
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a     = 8'($urandom);
                req0_shift = 3'($urandom);
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a     = 8'($urandom);
                req1_shift = 3'($urandom);
            end
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
            rst_n        = ($urandom_range(0, 149) != 0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
